menu_select_ctrl: RTL and testbench
===================================

Name: menu_select_ctrl

Overview:
- Sequences a vertical column of on-screen menu buttons: decides per frame which button is drawn as regular (REGU), which as selected (SLCT), or none (FREE).
- Handles up/down keypad navigation with edge detection and frame-based auto-repeat, confirms a choice with a flash sequence, and reports the chosen index to the game FSM.
- Sits between the keypad/frame-timing logic and the per-button drawing objects; its packed button_types output feeds each button's button_type input.

Parameters:
- NUM_BUTTONS, 4, number of menu buttons (2..8).
- WRAP, 1, 1 = index wraps at ends; 0 = index saturates at 0 / NUM_BUTTONS-1.
- REPEAT_DELAY, 20, frames a direction key must be held before the first auto-repeat step.
- REPEAT_RATE, 6, frames between subsequent auto-repeat steps (1..REPEAT_DELAY).
- FLASH_FRAMES, 16, length of the confirm flash sequence, in frames.

Ports:
- clk  in  1  system clock (VGA pixel clock domain).
- reset  in  1  synchronous, active-high reset.
- startOfFrame  in  1  one-cycle pulse per VGA frame.
- menu_start  in  1  pulse: open the menu.
- menu_abort  in  1  pulse: close the menu without a choice.
- key_up  in  1  level: up key held.
- key_down  in  1  level: down key held.
- key_enter  in  1  level: enter key held.
- button_types  out  3*NUM_BUTTONS  per-button type; field i is bits [3i+2:3i]. Encodings: FREE=000, REGU=001, SLCT=010.
- selected_index  out  3  currently highlighted button.
- menu_active  out  1  high in NAVIGATE or CONFIRM.
- choice_valid  out  1  one-cycle pulse when a choice completes.
- choice_index  out  3  chosen button; held until the next choice.

Behaviour:
- Reset values (applied synchronously while reset=1):
  - state=IDLE, selected_index=0, choice_index=0.
  - choice_valid=0, menu_active=0, button_types all FREE.
  - Internal key registers and all counters cleared.
  - Reset mid-operation aborts with no choice_valid.
- Edge detect: each key is registered every cycle. A press is (key & ~key_d).
- All outputs are registered. Every decision taken at edge k is visible after edge k.
- FSM states:
  - IDLE: all fields FREE. menu_start -> NAVIGATE, with selected_index=0.
  - NAVIGATE:
    - menu_abort (highest priority) -> IDLE.
    - Else enter press -> CONFIRM, and clear the flash counter.
    - Else a single up press -> index-1.
    - Else a single down press -> index+1.
    - Up and down pressed in the same cycle -> no move.
  - CONFIRM:
    - Navigation keys are ignored.
    - The flash counter increments on each startOfFrame.
    - Selected field is SLCT when counter[1]=0 and REGU when counter[1]=1, i.e. it toggles every 2 frames.
    - When the counter reaches FLASH_FRAMES -> DONE.
    - menu_abort -> IDLE.
  - DONE: for exactly one cycle, choice_valid=1 and choice_index=selected_index; then -> IDLE.
- button_types in NAVIGATE: field selected_index = SLCT, all other fields = REGU.
- Index arithmetic:
  - WRAP=1: up from 0 -> NUM_BUTTONS-1; down from NUM_BUTTONS-1 -> 0.
  - WRAP=0: the index clamps at both ends.
- Auto-repeat (NAVIGATE only):
  - Applies only when exactly one direction key is held.
  - The hold counter clears on a press or on release, and increments on startOfFrame while the key is held.
  - When the count reaches REPEAT_DELAY: step once, and reload the count to REPEAT_DELAY-REPEAT_RATE.
  - Holding both keys, or no key, clears the count.
- Simultaneous events:
  - Press and startOfFrame in the same cycle: the press wins and the count clears.
  - menu_start outside IDLE is ignored.
  - key_enter already held when entering NAVIGATE does not confirm; a fresh edge is required.

Test Plan:
- Reset, then menu_start -> menu_active=1, selected_index=0, button_types=REGU,REGU,REGU,SLCT (field 0 = SLCT), i.e. 12'b001_001_001_010.
- NAVIGATE at index 0, WRAP=1: one-cycle key_up -> index 3 on the next cycle. Repeat with WRAP=0 -> index stays 0. Three key_down pulses from 0 -> index 3.
- Hold key_down for 40 frames from index 0 (REPEAT_DELAY=20, RATE=6) -> steps at press, frame 20, frame 26, frame 32, frame 38 -> index 5 mod 4 = 1.
- key_enter at index 2 -> CONFIRM. Field 2 alternates SLCT/REGU every 2 frames. After 16 frames: one-cycle choice_valid=1, choice_index=2, then IDLE with all fields FREE.
- Assert reset during CONFIRM frame 8 -> next cycle state IDLE, choice_valid stays 0, choice_index=0. Separately, menu_abort during CONFIRM -> IDLE with no choice_valid.
- key_up and key_down rising in the same cycle -> index unchanged, no auto-repeat after 30 frames. key_enter held across menu_start -> no confirm until it is released and pressed again.

Source files
------------

// File: rtl/menu_select_ctrl.sv
// Vertical menu sequencer: keypad navigation with auto-repeat, confirm flash,
// and per-button REGU/SLCT/FREE type selection for the button drawing objects.
module menu_select_ctrl #(
    parameter int unsigned NUM_BUTTONS  = 4,
    parameter int unsigned WRAP         = 1,
    parameter int unsigned REPEAT_DELAY = 20,
    parameter int unsigned REPEAT_RATE  = 6,
    parameter int unsigned FLASH_FRAMES = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     startOfFrame,
    input  logic                     menu_start,
    input  logic                     menu_abort,
    input  logic                     key_up,
    input  logic                     key_down,
    input  logic                     key_enter,
    output logic [3*NUM_BUTTONS-1:0] button_types,
    output logic [2:0]               selected_index,
    output logic                     menu_active,
    output logic                     choice_valid,
    output logic [2:0]               choice_index
);

    localparam int unsigned HW = $clog2(REPEAT_DELAY + 1);
    localparam int unsigned FW = ($clog2(FLASH_FRAMES + 1) < 2) ? 2 : $clog2(FLASH_FRAMES + 1);
    localparam logic [2:0]  LAST = 3'(NUM_BUTTONS - 1);
    localparam logic [2:0]  FREE = 3'b000;
    localparam logic [2:0]  REGU = 3'b001;
    localparam logic [2:0]  SLCT = 3'b010;

    typedef enum logic [1:0] {IDLE, NAVIGATE, CONFIRM, DONE} state_t;

    state_t                   state, state_n;
    logic                     up_d, down_d, enter_d;
    logic [HW-1:0]            hold_cnt, hold_n, hold_inc;
    logic [FW-1:0]            flash_cnt, flash_n, flash_inc;
    logic [2:0]               sel_n, ci_n;
    logic                     cv_n, active_n;
    logic [3*NUM_BUTTONS-1:0] types_n;
    logic                     up_press, down_press, enter_press;

    function automatic logic [2:0] step_up(input logic [2:0] idx);
        if (idx == 3'd0)
            return (WRAP != 0) ? LAST : 3'd0;
        return idx - 3'd1;
    endfunction

    function automatic logic [2:0] step_down(input logic [2:0] idx);
        if (idx == LAST)
            return (WRAP != 0) ? 3'd0 : LAST;
        return idx + 3'd1;
    endfunction

    assign up_press    = key_up & ~up_d;
    assign down_press  = key_down & ~down_d;
    assign enter_press = key_enter & ~enter_d;

    always_comb begin
        state_n   = state;
        sel_n     = selected_index;
        hold_n    = hold_cnt;
        flash_n   = flash_cnt;
        cv_n      = 1'b0;
        ci_n      = choice_index;
        hold_inc  = hold_cnt + HW'(1);
        flash_inc = flash_cnt + FW'(1);

        case (state)
            IDLE: begin
                hold_n = '0;
                if (menu_start) begin
                    state_n = NAVIGATE;
                    sel_n   = 3'd0;
                end
            end
            NAVIGATE: begin
                if (menu_abort) begin
                    state_n = IDLE;
                    hold_n  = '0;
                end else if (enter_press) begin
                    state_n = CONFIRM;
                    flash_n = '0;
                    hold_n  = '0;
                end else begin
                    if (up_press && !down_press)
                        sel_n = step_up(selected_index);
                    else if (down_press && !up_press)
                        sel_n = step_down(selected_index);
                    // Repeat only counts while exactly one key is held with no fresh edge.
                    if (up_press || down_press || (key_up == key_down)) begin
                        hold_n = '0;
                    end else if (startOfFrame) begin
                        if (hold_inc == HW'(REPEAT_DELAY)) begin
                            hold_n = HW'(REPEAT_DELAY - REPEAT_RATE);
                            sel_n  = key_up ? step_up(selected_index) : step_down(selected_index);
                        end else begin
                            hold_n = hold_inc;
                        end
                    end
                end
            end
            CONFIRM: begin
                hold_n = '0;
                if (menu_abort) begin
                    state_n = IDLE;
                end else if (startOfFrame) begin
                    flash_n = flash_inc;
                    if (flash_inc == FW'(FLASH_FRAMES)) begin
                        state_n = DONE;
                        cv_n    = 1'b1;
                        ci_n    = selected_index;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        active_n = (state_n == NAVIGATE) || (state_n == CONFIRM);
        for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
            types_n[3*i +: 3] = FREE;
            if (state_n == NAVIGATE)
                types_n[3*i +: 3] = (3'(i) == sel_n) ? SLCT : REGU;
            else if (state_n == CONFIRM || state_n == DONE)
                types_n[3*i +: 3] = (3'(i) == sel_n) ? (flash_n[1] ? REGU : SLCT) : REGU;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            up_d           <= 1'b0;
            down_d         <= 1'b0;
            enter_d        <= 1'b0;
            hold_cnt       <= '0;
            flash_cnt      <= '0;
            selected_index <= 3'd0;
            choice_index   <= 3'd0;
            choice_valid   <= 1'b0;
            menu_active    <= 1'b0;
            button_types   <= '0;
        end else begin
            state          <= state_n;
            up_d           <= key_up;
            down_d         <= key_down;
            enter_d        <= key_enter;
            hold_cnt       <= hold_n;
            flash_cnt      <= flash_n;
            selected_index <= sel_n;
            choice_index   <= ci_n;
            choice_valid   <= cv_n;
            menu_active    <= active_n;
            button_types   <= types_n;
        end
    end

endmodule

// File: tb/tb_menu_select_ctrl.sv
// Bench for menu_select_ctrl: a wrapping and a saturating instance share stimulus;
// expected choices are queued when enter is pressed and popped on choice_valid.
module tb_menu_select_ctrl;

    logic        clk = 1'b0;
    logic        reset, sof, menu_start, menu_abort, key_up, key_down, key_enter;
    logic [11:0] types, types_s;
    logic [2:0]  idx, idx_s, ci, ci_s;
    logic        active, active_s, cv, cv_s;

    int          errors = 0;
    int          checks = 0;
    logic [2:0]  exp_choice[$];

    localparam logic [11:0] T_FREE  = 12'b000_000_000_000;
    localparam logic [11:0] T_ALLR  = 12'b001_001_001_001;
    localparam logic [11:0] T_SEL0  = 12'b001_001_001_010;
    localparam logic [11:0] T_SEL1  = 12'b001_001_010_001;
    localparam logic [11:0] T_SEL2  = 12'b001_010_001_001;
    localparam logic [11:0] T_SEL3  = 12'b010_001_001_001;

    always #5 clk = ~clk;

    menu_select_ctrl #(
        .NUM_BUTTONS(4), .WRAP(1), .REPEAT_DELAY(20), .REPEAT_RATE(6), .FLASH_FRAMES(16)
    ) dut (
        .clk(clk), .reset(reset), .startOfFrame(sof), .menu_start(menu_start),
        .menu_abort(menu_abort), .key_up(key_up), .key_down(key_down), .key_enter(key_enter),
        .button_types(types), .selected_index(idx), .menu_active(active),
        .choice_valid(cv), .choice_index(ci)
    );

    menu_select_ctrl #(
        .NUM_BUTTONS(4), .WRAP(0), .REPEAT_DELAY(20), .REPEAT_RATE(6), .FLASH_FRAMES(16)
    ) dut_sat (
        .clk(clk), .reset(reset), .startOfFrame(sof), .menu_start(menu_start),
        .menu_abort(menu_abort), .key_up(key_up), .key_down(key_down), .key_enter(key_enter),
        .button_types(types_s), .selected_index(idx_s), .menu_active(active_s),
        .choice_valid(cv_s), .choice_index(ci_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Every cycle advance passes through here so the choice scoreboard sees each pulse.
    task automatic tick();
        @(posedge clk);
        #1;
        if (cv) begin
            if (exp_choice.size() == 0)
                check("choice_unexpected", 32'(cv), 32'd0);
            else
                check("choice_index_sb", 32'(ci), 32'(exp_choice.pop_front()));
        end
    endtask

    task automatic frame();
        sof = 1'b1;
        tick();
        sof = 1'b0;
        tick();
    endtask

    task automatic pulse_up();
        key_up = 1'b1;
        tick();
        key_up = 1'b0;
        tick();
    endtask

    task automatic pulse_down();
        key_down = 1'b1;
        tick();
        key_down = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1; sof = 1'b0; menu_start = 1'b0; menu_abort = 1'b0;
        key_up = 1'b0; key_down = 1'b0; key_enter = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_active", 32'(active), 32'd0);
        check("rst_index", 32'(idx), 32'd0);
        check("rst_types", 32'(types), 32'(T_FREE));
        check("rst_valid", 32'(cv), 32'd0);
        check("rst_choice", 32'(ci), 32'd0);

        // open menu
        menu_start = 1'b1;
        tick();
        menu_start = 1'b0;
        check("open_active", 32'(active), 32'd1);
        check("open_index", 32'(idx), 32'd0);
        check("open_types", 32'(types), 32'(T_SEL0));
        check("open_index_sat", 32'(idx_s), 32'd0);

        // up from 0: wrap vs clamp
        key_up = 1'b1;
        tick();
        key_up = 1'b0;
        check("wrap_up", 32'(idx), 32'd3);
        check("clamp_up", 32'(idx_s), 32'd0);
        check("wrap_up_types", 32'(types), 32'(T_SEL3));
        tick();

        repeat (3) pulse_down();
        check("down3_wrap", 32'(idx), 32'd2);
        check("down3_sat", 32'(idx_s), 32'd3);
        pulse_down();
        check("down4_wrap", 32'(idx), 32'd3);
        check("clamp_down", 32'(idx_s), 32'd3);
        repeat (3) pulse_up();
        check("up3_wrap", 32'(idx), 32'd0);
        check("up3_sat", 32'(idx_s), 32'd0);

        // auto-repeat: hold down for 40 frames
        key_down = 1'b1;
        tick();
        check("hold_press", 32'(idx), 32'd1);
        for (int f = 1; f <= 40; f++) begin
            sof = 1'b1;
            tick();
            sof = 1'b0;
            if (f == 19) check("rep_f19", 32'(idx), 32'd1);
            if (f == 20) check("rep_f20", 32'(idx), 32'd2);
            if (f == 25) check("rep_f25", 32'(idx), 32'd2);
            if (f == 26) check("rep_f26", 32'(idx), 32'd3);
            if (f == 32) begin
                check("rep_f32", 32'(idx), 32'd0);
                check("rep_f32_sat", 32'(idx_s), 32'd3);
            end
            tick();
        end
        check("rep_end", 32'(idx), 32'd1);
        check("rep_end_sat", 32'(idx_s), 32'd3);
        key_down = 1'b0;
        tick();

        // confirm at index 2
        pulse_down();
        check("pre_confirm", 32'(idx), 32'd2);
        check("pre_confirm_sat", 32'(idx_s), 32'd3);
        key_enter = 1'b1;
        tick();
        key_enter = 1'b0;
        exp_choice.push_back(3'd2);
        check("conf_active", 32'(active), 32'd1);
        check("conf_types0", 32'(types), 32'(T_SEL2));
        for (int f = 1; f <= 16; f++) begin
            sof = 1'b1;
            key_up = (f == 3);
            tick();
            sof = 1'b0;
            key_up = 1'b0;
            if (f == 1) check("flash_f1", 32'(types), 32'(T_SEL2));
            if (f == 2) check("flash_f2", 32'(types), 32'(T_ALLR));
            if (f == 3) check("conf_nav_ignored", 32'(idx), 32'd2);
            if (f == 4) check("flash_f4", 32'(types), 32'(T_SEL2));
            if (f == 6) check("flash_f6", 32'(types), 32'(T_ALLR));
            if (f == 15) check("flash_f15_valid", 32'(cv), 32'd0);
            if (f == 16) begin
                check("done_valid", 32'(cv), 32'd1);
                check("done_index", 32'(ci), 32'd2);
                check("done_active", 32'(active), 32'd0);
            end
            tick();
        end
        check("post_valid", 32'(cv), 32'd0);
        check("post_types", 32'(types), 32'(T_FREE));
        check("post_choice_held", 32'(ci), 32'd2);

        // reset during confirm frame 8
        menu_start = 1'b1;
        tick();
        menu_start = 1'b0;
        key_enter = 1'b1;
        tick();
        key_enter = 1'b0;
        for (int f = 1; f <= 8; f++) begin
            sof = 1'b1;
            if (f == 8) reset = 1'b1;
            tick();
            sof = 1'b0;
            reset = 1'b0;
            if (f < 8) tick();
        end
        check("midrst_active", 32'(active), 32'd0);
        check("midrst_valid", 32'(cv), 32'd0);
        check("midrst_choice", 32'(ci), 32'd0);
        check("midrst_types", 32'(types), 32'(T_FREE));
        repeat (40) tick();

        // abort during confirm
        menu_start = 1'b1;
        tick();
        menu_start = 1'b0;
        key_enter = 1'b1;
        tick();
        key_enter = 1'b0;
        repeat (3) frame();
        menu_abort = 1'b1;
        tick();
        menu_abort = 1'b0;
        check("abort_active", 32'(active), 32'd0);
        check("abort_types", 32'(types), 32'(T_FREE));
        check("abort_valid", 32'(cv), 32'd0);
        repeat (20) frame();
        check("abort_choice", 32'(ci), 32'd0);

        // both directions at once
        menu_start = 1'b1;
        tick();
        menu_start = 1'b0;
        key_up = 1'b1;
        key_down = 1'b1;
        tick();
        check("both_press", 32'(idx), 32'd0);
        repeat (30) frame();
        check("both_hold", 32'(idx), 32'd0);
        check("both_hold_sat", 32'(idx_s), 32'd0);
        key_up = 1'b0;
        key_down = 1'b0;
        tick();

        // enter held across menu_start
        menu_abort = 1'b1;
        tick();
        menu_abort = 1'b0;
        key_enter = 1'b1;
        tick();
        tick();
        menu_start = 1'b1;
        tick();
        menu_start = 1'b0;
        check("held_enter_active", 32'(active), 32'd1);
        repeat (3) frame();
        key_down = 1'b1;
        tick();
        key_down = 1'b0;
        check("held_enter_no_confirm", 32'(idx), 32'd1);
        tick();
        menu_start = 1'b1;
        tick();
        menu_start = 1'b0;
        check("start_ignored", 32'(idx), 32'd1);
        key_enter = 1'b0;
        tick();
        key_enter = 1'b1;
        tick();
        exp_choice.push_back(3'd1);
        check("fresh_enter_types", 32'(types), 32'(T_SEL1));
        repeat (2) frame();
        check("fresh_enter_flash", 32'(types), 32'(T_ALLR));
        key_enter = 1'b0;
        repeat (14) frame();
        repeat (3) tick();
        check("final_choice", 32'(ci), 32'd1);
        check("sb_drained", 32'(exp_choice.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
